// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling
// ratio and the baud divisor calculation.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMP_W     = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clocks per oversample tick, truncated, never below one.
  function automatic int baud_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a write while full is accepted only
// when a read frees the head in the same cycle, otherwise it is reported as dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, pop, push;

  assign full   = (count_q == FULL_CNT);
  assign pop    = rd_en_i && (count_q != '0);
  assign push   = wr_en_i && (!full || pop);
  assign drop_o = wr_en_i && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
  // combinationally this cycle before the new byte overwrites that slot.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign valid_o   = (count_q != '0);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection and a
// small receive FIFO; framing errors and overruns are flagged as one-cycle pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] MID_TICK  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] LAST_TICK = SAMP_W'(OVERSAMPLE - 1);

  uart_state_e       state_q, state_d;
  logic [1:0]        sync_q;
  logic              din_s;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tick, push, ferr_d, drop;
  logic              frame_err_q, overrun_q;

  assign din_s = sync_q[1];
  assign tick  = (state_q != ST_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (state_q == ST_IDLE || tick) div_d = '0;
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        samp_d = '0;
        bit_d  = '0;
        if (!din_s) state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (samp_q == MID_TICK) begin
          samp_d  = '0;
          state_d = din_s ? ST_IDLE : ST_DATA;
        end else begin
          samp_d = samp_q + SAMP_W'(1);
        end
      end
      ST_DATA: if (tick) begin
        if (samp_q == LAST_TICK) begin
          samp_d  = '0;
          shift_d = {din_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          samp_d = samp_q + SAMP_W'(1);
        end
      end
      ST_STOP: if (tick) begin
        if (samp_q == LAST_TICK) begin
          samp_d  = '0;
          state_d = ST_IDLE;
          if (din_s) push = 1'b1;
          else       ferr_d = 1'b1;
        end else begin
          samp_d = samp_q + SAMP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      div_q       <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], din};
      div_q       <= div_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      frame_err_q <= ferr_d;
      overrun_q   <= drop;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (shift_q),
    .rd_en_i   (rx_ready),
    .rd_data_o (rx_data),
    .valid_o   (rx_valid),
    .count_o   (rx_count),
    .drop_o    (drop)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port din, input, 1, asynchronous serial line from the pin; idles high.
REQ-007 SHALL have port rx_data, output, 8, byte at the FIFO head.
REQ-008 SHALL have port rx_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port rx_ready, input, 1, consumer pops the head when rx_valid && rx_ready.
REQ-010 SHALL have port rx_count, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit samples low.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass din through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-014 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks, truncating division (default 325), with DIV minimum 1. The counter is free-running only while not IDLE and is cleared on entry to START.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on synchronized din = 0.
REQ-017 In START, at the 8th tick, SHALL sample din: 0 -> DATA; 1 -> IDLE (glitch rejected, no error pulse).
REQ-018 In DATA, SHALL sample every 16th tick, 8 bits, LSB first, then go to STOP.
REQ-019 In STOP, at the 16th tick, SHALL sample din. 1 -> push the byte. 0 -> pulse frame_err and discard the byte. Both cases return to IDLE.
REQ-020 Push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle; otherwise SHALL pulse overrun and leave the FIFO unchanged.
REQ-021 A pushed byte SHALL appear on rx_valid/rx_data in the cycle after the stop-bit sample when the FIFO was empty.
REQ-022 rx_data SHALL be stable while rx_valid && !rx_ready.
REQ-023 A pop with rx_valid = 0 SHALL have no effect.
REQ-024 Simultaneous push and pop SHALL keep rx_count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-027 On reset: FSM = IDLE; tick/bit counters = 0; synchronizer flops = 1; FIFO empty; rx_valid = 0; rx_count = 0; rx_data = 0; frame_err = 0; overrun = 0.
REQ-028 Reset mid-frame SHALL abort the frame with no push and no error pulse. If din is still low after reset, reception SHALL restart from IDLE.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding and OVERSAMPLE = 16, for reuse by the matching transmitter.
REQ-030 The FIFO SHALL be a separate sub-module sync_fifo (parameter WIDTH = 8, DEPTH); the baud divider and FSM stay in uart_rx_fifo.

Verification
REQ-031 Bench SHALL use CLK_HZ = 1600000 and BAUD = 100000 (DIV = 1, 16 clocks per bit).
REQ-032 Send 0xA5 with a good stop bit, rx_ready = 0 -> rx_valid = 1, rx_data = 0xA5, rx_count = 1; no error pulses.
REQ-033 Send 0x3C with stop bit held low -> exactly one frame_err pulse; rx_count unchanged; FSM back to IDLE; next frame 0x01 received correctly.
REQ-034 Drive a 4-clock low glitch on idle din -> no push, no error pulse; FSM in IDLE within 10 clocks.
REQ-035 With DEPTH = 4 and rx_ready = 0, send 0x11, 0x22, 0x33, 0x44, 0x55 -> rx_count = 4 and one overrun pulse. Then pop 4 times -> data order 0x11, 0x22, 0x33, 0x44, then rx_valid = 0.
REQ-036 With the FIFO full, assert rx_ready in the stop-sample cycle of 0x66 -> no overrun; rx_count stays 4; tail entry = 0x66.
REQ-037 Assert reset during data bit 4 of 0x99 -> all outputs at reset values next cycle; no byte pushed; a subsequent 0x5A is received correctly.
